// File: rtl/snn_pkg.sv
// Shared definitions for the spike window counter slice.
//   state_t   : window FSM states (IDLE, COUNT, DONE)
//   winner_w  : width of the winner index for a given channel count (min 1)
//   sat_max   : saturation ceiling of an unsigned counter of a given width
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int winner_w(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_max(int w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/spike_channel_counter.sv
// One spike channel: rising-edge detector plus saturating live counter.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   spike            : spike level, synchronous to clk
//   clear            : zero the live count and overflow this cycle
//   enable           : count rising edges this cycle
//   count_next       : value the live count takes at the next edge
//   ovf_next         : value the live overflow bit takes at the next edge
// The *_next outputs let the parent snapshot a window including the
// increments of its final cycle.
module spike_channel_counter
    import snn_pkg::*;
#(
    parameter int COUNTER_SIZE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spike,
    input  logic                    clear,
    input  logic                    enable,
    output logic [COUNTER_SIZE-1:0] count_next,
    output logic                    ovf_next
);

    localparam logic [COUNTER_SIZE-1:0] MAX = COUNTER_SIZE'(sat_max(COUNTER_SIZE));

    logic                    prev;
    logic                    rise;
    logic [COUNTER_SIZE-1:0] count;
    logic                    ovf;

    assign rise = spike & ~prev;

    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (clear) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (enable && rise) begin
            // Overflow only marks an increment attempted at the ceiling.
            if (count == MAX) begin
                ovf_next = 1'b1;
            end else begin
                count_next = count + COUNTER_SIZE'(1);
            end
        end
    end

    // prev tracks the level in every state so a level held across the
    // start boundary never looks like a fresh rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            prev  <= spike;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: rtl/spike_window_counter.sv
// Multi-channel synchronous spike counter over a programmable window.
// Optional feature macro: SPIKE_COUNTER_WINNER_EN (adds winner/winner_valid).
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   spike_in      : per-channel spike levels
//   start         : pulse; accepted only in IDLE or DONE (ignored in COUNT).
//                   No ready signal: the caller watches busy to know when a
//                   start will be taken. window_len is sampled with it.
//   window_len    : window length in cycles (0 completes immediately)
//   busy          : high while counting
//   done          : one-cycle pulse when the snapshot updates
//   counts_valid  : snapshot holds a completed window (sticky until reset)
//   counter_out   : snapshot counts per channel
//   overflow      : per-channel saturation flags of the snapshot window
//   winner        : (optional) lowest-index channel with the highest count
//   winner_valid  : (optional) snapshot has at least one non-zero count
//   state         : FSM state for debug (0 IDLE, 1 COUNT, 2 DONE)
module spike_window_counter
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS   = 4,
    parameter int COUNTER_SIZE = 4,
    parameter int WINDOW_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_INPUTS-1:0]               spike_in,
    input  logic                                start,
    input  logic [WINDOW_WIDTH-1:0]             window_len,
    output logic                                busy,
    output logic                                done,
    output logic                                counts_valid,
    output logic [COUNTER_SIZE-1:0]             counter_out [NUM_INPUTS],
    output logic [NUM_INPUTS-1:0]               overflow,
`ifdef SPIKE_COUNTER_WINNER_EN
    output logic [winner_w(NUM_INPUTS)-1:0]     winner,
    output logic                                winner_valid,
`endif
    output logic [1:0]                          state
);

    state_t                  state_r;
    logic [WINDOW_WIDTH-1:0] remaining;
    logic                    accept;
    logic                    enable;
    logic                    snap;
    logic [COUNTER_SIZE-1:0] next_count [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   ovf_next;

    assign state  = state_r;
    assign accept = start && (state_r == IDLE || state_r == DONE);
    assign enable = (state_r == COUNT);
    // Snapshot on every entry into DONE: end of a window, or a zero-length
    // start (whose next values are the cleared zeros).
    assign snap   = (enable && remaining == WINDOW_WIDTH'(1)) ||
                    (accept && window_len == '0);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        spike_channel_counter #(
            .COUNTER_SIZE(COUNTER_SIZE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .spike      (spike_in[g]),
            .clear      (accept),
            .enable     (enable),
            .count_next (next_count[g]),
            .ovf_next   (ovf_next[g])
        );
    end

`ifdef SPIKE_COUNTER_WINNER_EN
    logic [winner_w(NUM_INPUTS)-1:0] best_idx;
    logic [COUNTER_SIZE-1:0]         best_val;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = next_count[0];
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (next_count[i] > best_val) begin
                best_val = next_count[i];
                best_idx = winner_w(NUM_INPUTS)'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            counts_valid <= 1'b0;
            overflow     <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                counter_out[i] <= '0;
            end
`ifdef SPIKE_COUNTER_WINNER_EN
            winner       <= '0;
            winner_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= window_len;
                        if (window_len == '0) begin
                            state_r <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= COUNT;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                COUNT: begin
                    remaining <= remaining - WINDOW_WIDTH'(1);
                    if (remaining == WINDOW_WIDTH'(1)) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase

            if (snap) begin
                counter_out  <= next_count;
                overflow     <= ovf_next;
                counts_valid <= 1'b1;
`ifdef SPIKE_COUNTER_WINNER_EN
                winner       <= best_idx;
                winner_valid <= (best_val != '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// Bench for spike_window_counter: per-window spike histories are scored
// against counts derived directly from the rising-edge definition.
module tb_spike_window_counter;

    localparam int N  = 4;
    localparam int CS = 4;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          start = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic          busy;
    logic          done;
    logic          counts_valid;
    logic [CS-1:0] counter_out [N];
    logic [N-1:0]  overflow;
    logic [1:0]    state;
`ifdef SPIKE_COUNTER_WINNER_EN
    logic [1:0]    winner;
    logic          winner_valid;
`endif

    spike_window_counter #(
        .NUM_INPUTS   (N),
        .COUNTER_SIZE (CS),
        .WINDOW_WIDTH (WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spike_in     (spike_in),
        .start        (start),
        .window_len   (window_len),
        .busy         (busy),
        .done         (done),
        .counts_valid (counts_valid),
        .counter_out  (counter_out),
        .overflow     (overflow),
`ifdef SPIKE_COUNTER_WINNER_EN
        .winner       (winner),
        .winner_valid (winner_valid),
`endif
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stim[0] is the level at the accepting edge, stim[k] the level sampled
    // at the k-th counting edge.
    logic [N-1:0]  stim [0:255];
    logic [19:0]   exp_q [$];   // {overflow[3:0], count3, count2, count1, count0}
    logic [19:0]   last_exp = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] dut_snap();
        return {overflow, counter_out[3], counter_out[2], counter_out[1], counter_out[0]};
    endfunction

    // Reference: count 0->1 transitions of each channel over the window.
    function automatic logic [19:0] model(int len);
        logic [19:0] r;
        r = '0;
        for (int c = 0; c < N; c++) begin
            int rises;
            rises = 0;
            for (int k = 1; k <= len; k++) begin
                if (stim[k][c] && !stim[k-1][c]) rises++;
            end
            r[c*4 +: 4] = (rises > 15) ? 4'd15 : 4'(rises);
            r[16 + c]   = (rises > 15);
        end
        return r;
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Leaves the bench #1 after the DONE-entry edge; calling it again at
    // once issues the next start inside the DONE cycle.
    task automatic run_window(input int len, input bit poke_start);
        logic [19:0] exp;
        exp_q.push_back(model(len));
        start      = 1'b1;
        window_len = WW'(len);
        spike_in   = stim[0];
        step();
        start = 1'b0;
        for (int k = 1; k <= len; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || dut_snap() !== last_exp) begin
                errors++;
                $display("FAIL counting k=%0d len=%0d: busy=%b done=%b snap=%h, expected busy=1 done=0 snap=%h",
                         k, len, busy, done, dut_snap(), last_exp);
            end
            spike_in = stim[k];
            if (poke_start && k == 2) begin
                start      = 1'b1;
                window_len = 8'd3;
            end
            step();
            start = 1'b0;
        end
        exp = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || counts_valid !== 1'b1 || dut_snap() !== exp) begin
            errors++;
            $display("FAIL window_end len=%0d: done=%b busy=%b valid=%b snap=%h, expected done=1 busy=0 valid=1 snap=%h",
                     len, done, busy, counts_valid, dut_snap(), exp);
        end
        last_exp = exp;
`ifdef SPIKE_COUNTER_WINNER_EN
        begin
            int best;
            best = 0;
            for (int c = 1; c < N; c++) begin
                if (exp[c*4 +: 4] > exp[best*4 +: 4]) best = c;
            end
            checks++;
            if (winner !== 2'(best) || winner_valid !== (exp[best*4 +: 4] != 4'd0)) begin
                errors++;
                $display("FAIL winner len=%0d: winner=%0d valid=%b, expected winner=%0d valid=%b",
                         len, winner, winner_valid, best, (exp[best*4 +: 4] != 4'd0));
            end
        end
`endif
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 256; k++) stim[k] = '0;
    endtask

    task automatic rand_stim(input int len);
        for (int k = 0; k <= len; k++) stim[k] = N'($urandom_range(0, 15));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || counts_valid !== 1'b0 || dut_snap() !== 20'h0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b snap=%h state=%0d, expected all 0",
                     busy, done, counts_valid, dut_snap(), state);
        end
        step();
        step();
        rst = 1'b1;
        step();
        // Reset in the middle of a window.
        start      = 1'b1;
        window_len = 8'd10;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            spike_in = N'($urandom_range(0, 15));
            step();
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || counts_valid !== 1'b0 || dut_snap() !== 20'h0 || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_window: busy=%b done=%b valid=%b snap=%h state=%0d, expected all 0",
                     busy, done, counts_valid, dut_snap(), state);
        end
        step();
        rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            spike_in = N'($urandom_range(0, 15));
            step();
            checks++;
            if (done !== 1'b0 || state !== 2'd0 || counts_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done k=%0d: done=%b state=%0d valid=%b, expected 0 0 0",
                         k, done, state, counts_valid);
            end
        end
        last_exp = '0;
        spike_in = '0;
    endtask

    task automatic test_basic();
        clear_stim();
        for (int k = 1; k <= 8; k++) stim[k][1] = 1'b1;
        stim[2][0] = 1'b1;
        stim[4][0] = 1'b1;
        stim[6][0] = 1'b1;
        run_window(8, 1'b0);
        checks++;
        if (counter_out[0] !== 4'd3 || counter_out[1] !== 4'd1 || overflow !== 4'd0) begin
            errors++;
            $display("FAIL basic_counts: ch0=%0d ch1=%0d ovf=%b, expected 3 1 0000",
                     counter_out[0], counter_out[1], overflow);
        end
        step();
        checks++;
        if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: state=%0d busy=%b done=%b, expected 0 0 0", state, busy, done);
        end
    endtask

    task automatic test_saturation();
        clear_stim();
        for (int k = 1; k <= 40; k++) stim[k][2] = (k % 2 == 1);
        run_window(40, 1'b0);
        checks++;
        if (counter_out[2] !== 4'd15 || overflow !== 4'b0100 || counter_out[0] !== 4'd0 ||
            counter_out[1] !== 4'd0 || counter_out[3] !== 4'd0) begin
            errors++;
            $display("FAIL saturation: ch2=%0d ovf=%b snap=%h, expected ch2=15 ovf=0100 others 0",
                     counter_out[2], overflow, dut_snap());
        end
        step();
    endtask

    task automatic test_boundary();
        clear_stim();
        stim[0] = 4'b1000;
        stim[1] = 4'b1001;
        for (int k = 2; k <= 5; k++) stim[k] = 4'b1000;
        stim[6] = 4'b1011;
        run_window(6, 1'b0);
        checks++;
        if (dut_snap() !== 20'h00012) begin
            errors++;
            $display("FAIL boundary_edges: snap=%h, expected 00012", dut_snap());
        end
        // A rise sampled in the DONE cycle belongs to no window.
        spike_in = 4'b0100;
        step();
        step();
        checks++;
        if (dut_snap() !== last_exp || done !== 1'b0) begin
            errors++;
            $display("FAIL boundary_after: snap=%h done=%b, expected snap=%h done=0",
                     dut_snap(), done, last_exp);
        end
        rand_stim(0);
        run_window(0, 1'b0);
        checks++;
        if (dut_snap() !== 20'h0 || counts_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: snap=%h valid=%b, expected 00000 1", dut_snap(), counts_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        rand_stim(5);
        run_window(5, 1'b0);
        rand_stim(4);
        run_window(4, 1'b1);
        rand_stim(0);
        run_window(0, 1'b0);
        rand_stim(3);
        run_window(3, 1'b1);
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int len;
            int gap;
            len = $urandom_range(1, 30);
            gap = $urandom_range(0, 2);
            for (int k = 0; k <= len; k++) begin
                stim[k] = (k > 0 && $urandom_range(0, 1) == 1) ? stim[k-1] : N'($urandom_range(0, 15));
            end
            run_window(len, (len >= 3) && ($urandom_range(0, 1) == 1));
            for (int g = 0; g < gap; g++) step();
        end
        step();
    endtask

`ifdef SPIKE_COUNTER_WINNER_EN
    task automatic test_winner();
        clear_stim();
        for (int k = 1; k <= 10; k++) begin
            stim[k][0] = (k == 1 || k == 3);
            stim[k][1] = (k % 2 == 1);
            stim[k][2] = (k % 2 == 1);
            stim[k][3] = (k == 1);
        end
        run_window(10, 1'b0);
        checks++;
        if (winner !== 2'd1 || winner_valid !== 1'b1 || dut_snap() !== 20'h01552) begin
            errors++;
            $display("FAIL winner_tie: winner=%0d valid=%b snap=%h, expected 1 1 01552",
                     winner, winner_valid, dut_snap());
        end
        step();
        clear_stim();
        run_window(5, 1'b0);
        checks++;
        if (winner !== 2'd0 || winner_valid !== 1'b0) begin
            errors++;
            $display("FAIL winner_zero: winner=%0d valid=%b, expected 0 0", winner, winner_valid);
        end
        step();
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_boundary();
        test_back_to_back();
        test_random();
`ifdef SPIKE_COUNTER_WINNER_EN
        test_winner();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
